// File: rtl/cordic_bist_pkg.sv
// Shared definitions for the CORDIC wrapper BIST controller: FSM encoding,
// wrapper mode/bypass bit positions and the DUT reset pulse length.
package cordic_bist_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_DRST = 3'd1;
  localparam logic [STATE_W-1:0] ST_SEED = 3'd2;
  localparam logic [STATE_W-1:0] ST_RUN  = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE = 3'd4;

  localparam int unsigned MODE_SA_BIT  = 0;
  localparam int unsigned MODE_DRV_BIT = 1;

  localparam int unsigned BYP_IN_BIT   = 0;
  localparam int unsigned BYP_CORE_BIT = 1;
  localparam int unsigned BYP_OUT_BIT  = 2;

  // Long enough to flush the wrapper's 2-flop reset synchronizer.
  localparam int unsigned DRST_LEN   = 4;
  localparam int unsigned DRST_CNT_W = 2;

endpackage

// File: rtl/cordic_bist_ctrl.sv
// BIST sequencer for cordic_wrapper: reset, seed, run, capture and compare.
// Optional RUN watchdog enabled by defining CORDIC_BIST_TIMEOUT_EN.
module cordic_bist_ctrl
  import cordic_bist_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 56,
  parameter int unsigned SIG_WIDTH  = 54,
  parameter int unsigned STOP_WIDTH = 49,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_async_rst_n,
  input  logic                  i_start,
  input  logic [1:0]            i_cfg_mode,
  input  logic [2:0]            i_cfg_bypass,
  input  logic [DATA_WIDTH-1:0] i_seed,
  input  logic [STOP_WIDTH-1:0] i_stop_code,
  input  logic [SIG_WIDTH-1:0]  i_golden,
  input  logic [CNT_WIDTH-1:0]  i_run_len,
  input  logic [CNT_WIDTH-1:0]  i_timeout,
  output logic                  o_dut_rst,
  output logic                  o_dut_en,
  output logic [1:0]            o_dut_mode,
  output logic [2:0]            o_dut_bypass,
  output logic [STOP_WIDTH-1:0] o_dut_stop_code,
  output logic                  o_dut_vld,
  output logic [DATA_WIDTH-1:0] o_dut_data,
  input  logic                  i_dut_vld,
  input  logic [DATA_WIDTH-1:0] i_dut_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic                  o_timeout,
  output logic [SIG_WIDTH-1:0]  o_signature
);

  localparam int unsigned CW1 = CNT_WIDTH + 1;

  logic [STATE_W-1:0]    state_q, state_nxt;
  logic [DRST_CNT_W-1:0] drst_cnt_q, drst_cnt_nxt;
  logic [CNT_WIDTH-1:0]  vld_cnt_q, vld_cnt_nxt;
  logic [DATA_WIDTH-1:0] seed_q, seed_nxt;
  logic [SIG_WIDTH-1:0]  golden_q, golden_nxt;
  logic [CNT_WIDTH-1:0]  run_len_q, run_len_nxt;
  logic [1:0]            mode_nxt;
  logic [2:0]            bypass_nxt;
  logic [STOP_WIDTH-1:0] stop_nxt;
  logic [SIG_WIDTH-1:0]  sig_nxt;
  logic                  done_nxt, pass_nxt, capture;
  logic                  dut_rst_nxt, busy_nxt, dut_vld_nxt;
  logic [DATA_WIDTH-1:0] dut_data_nxt;
  logic [CW1-1:0]        vld_ord, eff_len;
  logic                  unused_data;

  // Whole bus folded so the bits above the signature do not dangle.
  assign unused_data = ^i_dut_data;
  assign vld_ord = CW1'(vld_cnt_q) + CW1'(1);
  assign eff_len = (run_len_q == '0) ? CW1'(1) : CW1'(run_len_q);

`ifdef CORDIC_BIST_TIMEOUT_EN
  logic [CNT_WIDTH-1:0] timeout_q, timeout_nxt;
  logic [CNT_WIDTH-1:0] run_cnt_q, run_cnt_nxt;
  logic                 tmo_nxt;
`else
  logic unused_timeout;
  assign unused_timeout = ^i_timeout;
  assign o_timeout      = 1'b0;
`endif

  // Next-state, configuration latch and result capture.
  always_comb begin
    state_nxt    = state_q;
    drst_cnt_nxt = drst_cnt_q;
    vld_cnt_nxt  = vld_cnt_q;
    seed_nxt     = seed_q;
    golden_nxt   = golden_q;
    run_len_nxt  = run_len_q;
    mode_nxt     = o_dut_mode;
    bypass_nxt   = o_dut_bypass;
    stop_nxt     = o_dut_stop_code;
    sig_nxt      = o_signature;
    done_nxt     = o_done;
    pass_nxt     = o_pass;
    capture      = 1'b0;
`ifdef CORDIC_BIST_TIMEOUT_EN
    timeout_nxt  = timeout_q;
    run_cnt_nxt  = run_cnt_q;
    tmo_nxt      = o_timeout;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_nxt                = ST_DRST;
          drst_cnt_nxt             = '0;
          mode_nxt[MODE_SA_BIT]    = i_cfg_mode[MODE_SA_BIT];
          mode_nxt[MODE_DRV_BIT]   = i_cfg_mode[MODE_DRV_BIT];
          bypass_nxt[BYP_IN_BIT]   = i_cfg_bypass[BYP_IN_BIT];
          bypass_nxt[BYP_CORE_BIT] = i_cfg_bypass[BYP_CORE_BIT];
          bypass_nxt[BYP_OUT_BIT]  = i_cfg_bypass[BYP_OUT_BIT];
          stop_nxt                 = i_stop_code;
          seed_nxt                 = i_seed;
          golden_nxt               = i_golden;
          run_len_nxt              = i_run_len;
          done_nxt                 = 1'b0;
          pass_nxt                 = 1'b0;
`ifdef CORDIC_BIST_TIMEOUT_EN
          timeout_nxt              = i_timeout;
          tmo_nxt                  = 1'b0;
`endif
        end
      end
      ST_DRST: begin
        if (drst_cnt_q == DRST_CNT_W'(DRST_LEN - 1)) begin
          state_nxt = ST_SEED;
        end else begin
          drst_cnt_nxt = drst_cnt_q + DRST_CNT_W'(1);
        end
      end
      ST_SEED: begin
        state_nxt   = ST_RUN;
        vld_cnt_nxt = '0;
`ifdef CORDIC_BIST_TIMEOUT_EN
        run_cnt_nxt = '0;
`endif
      end
      ST_RUN: begin
        if (i_dut_vld) begin
          if (o_dut_mode[MODE_SA_BIT] || (vld_ord >= eff_len)) begin
            capture = 1'b1;
          end else begin
            vld_cnt_nxt = vld_cnt_q + CNT_WIDTH'(1);
          end
        end
        if (capture) begin
          state_nxt = ST_DONE;
          sig_nxt   = i_dut_data[SIG_WIDTH-1:0];
          done_nxt  = 1'b1;
          pass_nxt  = (i_dut_data[SIG_WIDTH-1:0] == golden_q);
        end
`ifdef CORDIC_BIST_TIMEOUT_EN
        else if ((timeout_q != '0) &&
                 (CW1'(run_cnt_q) + CW1'(1) == CW1'(timeout_q))) begin
          state_nxt = ST_DONE;
          sig_nxt   = '0;
          done_nxt  = 1'b1;
          pass_nxt  = 1'b0;
          tmo_nxt   = 1'b1;
        end else begin
          run_cnt_nxt = run_cnt_q + CNT_WIDTH'(1);
        end
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase

    dut_rst_nxt  = (state_nxt == ST_IDLE) || (state_nxt == ST_DRST);
    busy_nxt     = (state_nxt == ST_DRST) || (state_nxt == ST_SEED) ||
                   (state_nxt == ST_RUN);
    dut_vld_nxt  = (state_nxt == ST_SEED);
    dut_data_nxt = (state_nxt == ST_SEED) ? seed_q : '0;
  end

  // State, configuration and registered outputs.
  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      state_q         <= ST_IDLE;
      drst_cnt_q      <= '0;
      vld_cnt_q       <= '0;
      seed_q          <= '0;
      golden_q        <= '0;
      run_len_q       <= '0;
      o_dut_rst       <= 1'b1;
      o_dut_en        <= 1'b0;
      o_dut_mode      <= '0;
      o_dut_bypass    <= '0;
      o_dut_stop_code <= '0;
      o_dut_vld       <= 1'b0;
      o_dut_data      <= '0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_pass          <= 1'b0;
      o_signature     <= '0;
    end else begin
      state_q         <= state_nxt;
      drst_cnt_q      <= drst_cnt_nxt;
      vld_cnt_q       <= vld_cnt_nxt;
      seed_q          <= seed_nxt;
      golden_q        <= golden_nxt;
      run_len_q       <= run_len_nxt;
      o_dut_rst       <= dut_rst_nxt;
      o_dut_en        <= busy_nxt;
      o_dut_mode      <= mode_nxt;
      o_dut_bypass    <= bypass_nxt;
      o_dut_stop_code <= stop_nxt;
      o_dut_vld       <= dut_vld_nxt;
      o_dut_data      <= dut_data_nxt;
      o_busy          <= busy_nxt;
      o_done          <= done_nxt;
      o_pass          <= pass_nxt;
      o_signature     <= sig_nxt;
    end
  end

`ifdef CORDIC_BIST_TIMEOUT_EN
  // RUN watchdog.
  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      timeout_q <= '0;
      run_cnt_q <= '0;
      o_timeout <= 1'b0;
    end else begin
      timeout_q <= timeout_nxt;
      run_cnt_q <= run_cnt_nxt;
      o_timeout <= tmo_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_cordic_bist_ctrl.sv
// Directed self-checking bench for cordic_bist_ctrl (both CORDIC_BIST_TIMEOUT_EN builds).
module tb_cordic_bist_ctrl;

  logic        i_clk = 1'b0;
  logic        i_async_rst_n;
  logic        i_start;
  logic [1:0]  i_cfg_mode;
  logic [2:0]  i_cfg_bypass;
  logic [55:0] i_seed;
  logic [48:0] i_stop_code;
  logic [53:0] i_golden;
  logic [15:0] i_run_len;
  logic [15:0] i_timeout;
  logic        o_dut_rst, o_dut_en, o_dut_vld;
  logic [1:0]  o_dut_mode;
  logic [2:0]  o_dut_bypass;
  logic [48:0] o_dut_stop_code;
  logic [55:0] o_dut_data;
  logic        i_dut_vld;
  logic [55:0] i_dut_data;
  logic        o_busy, o_done, o_pass, o_timeout;
  logic [53:0] o_signature;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  cordic_bist_ctrl dut (
    .i_clk(i_clk), .i_async_rst_n(i_async_rst_n), .i_start(i_start),
    .i_cfg_mode(i_cfg_mode), .i_cfg_bypass(i_cfg_bypass), .i_seed(i_seed),
    .i_stop_code(i_stop_code), .i_golden(i_golden), .i_run_len(i_run_len),
    .i_timeout(i_timeout), .o_dut_rst(o_dut_rst), .o_dut_en(o_dut_en),
    .o_dut_mode(o_dut_mode), .o_dut_bypass(o_dut_bypass),
    .o_dut_stop_code(o_dut_stop_code), .o_dut_vld(o_dut_vld),
    .o_dut_data(o_dut_data), .i_dut_vld(i_dut_vld), .i_dut_data(i_dut_data),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_timeout(o_timeout),
    .o_signature(o_signature)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Pulse start with the given config, then scramble the config inputs.
  task automatic do_start(input logic [1:0] mode, input logic [2:0] byp,
                          input logic [55:0] seed, input logic [48:0] stop,
                          input logic [53:0] golden, input logic [15:0] len,
                          input logic [15:0] tmo);
    i_cfg_mode = mode; i_cfg_bypass = byp; i_seed = seed; i_stop_code = stop;
    i_golden = golden; i_run_len = len; i_timeout = tmo; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_seed = ~seed; i_golden = ~golden; i_run_len = len + 16'd7;
    i_timeout = tmo + 16'd3; i_cfg_mode = ~mode; i_cfg_bypass = ~byp;
  endtask

  // Walk DRST and SEED with garbage on i_dut_vld; leaves the DUT in RUN.
  task automatic prologue(input logic [55:0] seed);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (o_dut_rst !== 1'b1 || o_dut_en !== 1'b1 || o_busy !== 1'b1 ||
          o_dut_vld !== 1'b0 || o_done !== 1'b0) begin
        n_fail++;
        $display("FAIL drst_cycle%0d: rst=%b en=%b busy=%b vld=%b done=%b, required 1 1 1 0 0",
                 i, o_dut_rst, o_dut_en, o_busy, o_dut_vld, o_done);
      end
      i_dut_vld = 1'b1; i_dut_data = 56'hFF_FFFF_FFFF_FFFF;
      tick();
    end
    n_checks++;
    if (o_dut_vld !== 1'b1 || o_dut_data !== seed || o_dut_rst !== 1'b0 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL seed: vld=%b data=%h rst=%b busy=%b, required 1 %h 0 1",
               o_dut_vld, o_dut_data, o_dut_rst, o_busy, seed);
    end
    tick();
    i_dut_vld = 1'b0; i_dut_data = '0;
    n_checks++;
    if (o_dut_vld !== 1'b0 || o_busy !== 1'b1 || o_dut_en !== 1'b1 || o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL run_entry: vld=%b busy=%b en=%b done=%b, required 0 1 1 0",
               o_dut_vld, o_busy, o_dut_en, o_done);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (o_dut_rst !== 1'b1 || o_dut_en !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 ||
        o_pass !== 1'b0 || o_timeout !== 1'b0 || o_dut_vld !== 1'b0 ||
        o_signature !== '0 || o_dut_mode !== '0 || o_dut_data !== '0) begin
      n_fail++;
      $display("FAIL reset_values: rst=%b en=%b busy=%b done=%b pass=%b tmo=%b vld=%b sig=%h mode=%b, required 1 0 0 0 0 0 0 0 0",
               o_dut_rst, o_dut_en, o_busy, o_done, o_pass, o_timeout, o_dut_vld, o_signature, o_dut_mode);
    end
  endtask

  task automatic test_sa_mode();
    logic [53:0] gold;
    gold = 54'h2A5A5A12345678;
    do_start(2'b11, 3'b000, 56'hC0FFEE_0000_1234, 49'h0_1111_2222_3333, gold, 16'd5, 16'd0);
    prologue(56'hC0FFEE_0000_1234);
    for (int i = 0; i < 19; i++) tick();
    n_checks++;
    if (o_busy !== 1'b1 || o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL sa_wait: busy=%b done=%b, required 1 0", o_busy, o_done);
    end
    i_dut_vld = 1'b1; i_dut_data = {2'b11, gold};
    tick();
    i_dut_vld = 1'b0; i_dut_data = '0;
    n_checks++;
    if (o_done !== 1'b1 || o_pass !== 1'b1 || o_busy !== 1'b0 || o_dut_en !== 1'b0 ||
        o_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL sa_done: done=%b pass=%b busy=%b en=%b tmo=%b, required 1 1 0 0 0",
               o_done, o_pass, o_busy, o_dut_en, o_timeout);
    end
    n_checks++;
    if (o_signature !== gold || o_dut_mode !== 2'b11) begin
      n_fail++;
      $display("FAIL sa_signature: sig=%h mode=%b, required %h 11", o_signature, o_dut_mode, gold);
    end
    tick();
    n_checks++;
    if (o_done !== 1'b1 || o_pass !== 1'b1) begin
      n_fail++;
      $display("FAIL sa_hold: done=%b pass=%b, required 1 1", o_done, o_pass);
    end
  endtask

  task automatic test_direct_mode();
    for (int k = 0; k < 2; k++) begin
      do_start(2'b00, 3'b011, 56'h12, 49'h5, (k == 0) ? 54'h3 : 54'h5, 16'd3, 16'd0);
      prologue(56'h12);
      i_dut_vld = 1'b1; i_dut_data = 56'h1;
      tick();
      i_dut_vld = 1'b0;
      tick();
      i_dut_vld = 1'b1; i_dut_data = 56'h2;
      tick();
      n_checks++;
      if (o_done !== 1'b0 || o_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL direct_early_%0d: done=%b busy=%b, required 0 1", k, o_done, o_busy);
      end
      i_dut_data = 56'h3;
      tick();
      i_dut_vld = 1'b0; i_dut_data = '0;
      n_checks++;
      if (o_done !== 1'b1 || o_signature !== 54'h3 || o_pass !== (k == 0) || o_dut_bypass !== 3'b011) begin
        n_fail++;
        $display("FAIL direct_capture_%0d: done=%b sig=%h pass=%b byp=%b, required 1 3 %0b 011",
                 k, o_done, o_signature, o_pass, o_dut_bypass, (k == 0));
      end
    end
  endtask

  task automatic test_run_len_zero();
    do_start(2'b00, 3'b000, 56'h77, 49'h0, 54'h2A, 16'd0, 16'd0);
    prologue(56'h77);
    tick();
    i_dut_vld = 1'b1; i_dut_data = 56'h2A;
    tick();
    i_dut_vld = 1'b0; i_dut_data = '0;
    n_checks++;
    if (o_done !== 1'b1 || o_pass !== 1'b1 || o_signature !== 54'h2A) begin
      n_fail++;
      $display("FAIL run_len_zero: done=%b pass=%b sig=%h, required 1 1 2a", o_done, o_pass, o_signature);
    end
  endtask

  task automatic test_start_ignored();
    do_start(2'b00, 3'b101, 56'hABC, 49'h1_2345_6789_ABCD, 54'h55, 16'd2, 16'd0);
    prologue(56'hABC);
    i_start = 1'b1; i_cfg_mode = 2'b11; i_cfg_bypass = 3'b010; i_stop_code = '0;
    i_run_len = 16'd1; i_golden = 54'h11;
    tick();
    i_start = 1'b0;
    n_checks++;
    if (o_dut_mode !== 2'b00 || o_dut_bypass !== 3'b101 ||
        o_dut_stop_code !== 49'h1_2345_6789_ABCD || o_busy !== 1'b1 || o_dut_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ignored_cfg: mode=%b byp=%b stop=%h busy=%b rst=%b, required 00 101 123456789abcd 1 0",
               o_dut_mode, o_dut_bypass, o_dut_stop_code, o_busy, o_dut_rst);
    end
    i_dut_vld = 1'b1; i_dut_data = 56'h11;
    tick();
    n_checks++;
    if (o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ignored_len: done=%b, required 0", o_done);
    end
    i_dut_data = 56'h55;
    tick();
    i_dut_vld = 1'b0; i_dut_data = '0;
    n_checks++;
    if (o_done !== 1'b1 || o_pass !== 1'b1 || o_signature !== 54'h55) begin
      n_fail++;
      $display("FAIL start_ignored_result: done=%b pass=%b sig=%h, required 1 1 55", o_done, o_pass, o_signature);
    end
  endtask

  // Restart from DONE, then hit reset in the middle of RUN.
  task automatic test_restart_and_reset();
    do_start(2'b01, 3'b000, 56'h9, 49'h3, 54'h9, 16'd1, 16'd0);
    prologue(56'h9);
    tick(); tick();
    #2 i_async_rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_dut_rst !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_dut_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_run: rst=%b busy=%b done=%b en=%b, required 1 0 0 0",
               o_dut_rst, o_busy, o_done, o_dut_en);
    end
    tick();
    i_async_rst_n = 1'b1;
    i_dut_vld = 1'b1; i_dut_data = 56'h9;
    tick(); tick();
    i_dut_vld = 1'b0; i_dut_data = '0;
    n_checks++;
    if (o_dut_rst !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_signature !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: rst=%b busy=%b done=%b sig=%h, required 1 0 0 0",
               o_dut_rst, o_busy, o_done, o_signature);
    end
  endtask

  task automatic test_timeout();
    do_start(2'b01, 3'b000, 56'h4, 49'h0, 54'h0, 16'd1, 16'd10);
    prologue(56'h4);
`ifdef CORDIC_BIST_TIMEOUT_EN
    for (int i = 0; i < 9; i++) tick();
    n_checks++;
    if (o_busy !== 1'b1 || o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: busy=%b done=%b, required 1 0", o_busy, o_done);
    end
    tick();
    n_checks++;
    if (o_done !== 1'b1 || o_timeout !== 1'b1 || o_pass !== 1'b0 || o_signature !== '0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_done: done=%b tmo=%b pass=%b sig=%h busy=%b, required 1 1 0 0 0",
               o_done, o_timeout, o_pass, o_signature, o_busy);
    end
`else
    for (int i = 0; i < 40; i++) tick();
    n_checks++;
    if (o_busy !== 1'b1 || o_done !== 1'b0 || o_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL no_timeout_wait: busy=%b done=%b tmo=%b, required 1 0 0", o_busy, o_done, o_timeout);
    end
`endif
  endtask

  initial begin
    i_async_rst_n = 1'b0; i_start = 1'b0; i_cfg_mode = '0; i_cfg_bypass = '0;
    i_seed = '0; i_stop_code = '0; i_golden = '0; i_run_len = '0; i_timeout = '0;
    i_dut_vld = 1'b0; i_dut_data = '0;
    tick(); tick();
    test_reset();
    i_async_rst_n = 1'b1;
    tick();
    test_reset();
    test_sa_mode();
    test_direct_mode();
    test_run_len_zero();
    test_start_ignored();
    test_restart_and_reset();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
